// File: rtl/vector_result_buffer_if.sv
// Handshake bundle between an execute stage, the vector result buffer and its consumer.
// The slave modport is the buffer side; the master modport drives stimulus and takes results.
interface vector_result_buffer_if #(
  parameter int LANES = 6,
  parameter int WIDTH = 8
);
  logic                     in_valid;
  logic                     in_ready;
  logic [LANES*WIDTH-1:0]   vector_in;
  logic [2*LANES-1:0]       flags_in;
  logic [2:0]               rd_in;
  logic                     out_valid;
  logic                     out_ready;
  logic [LANES*WIDTH-1:0]   vector_out;
  logic [2*LANES-1:0]       flags_out;
  logic [2:0]               rd_out;
  logic                     flush;
  logic                     clear_sticky;
  logic [2*LANES-1:0]       sticky_flags;
  logic [1:0]               count;

  modport slave (
    input  in_valid, vector_in, flags_in, rd_in, out_ready, flush, clear_sticky,
    output in_ready, out_valid, vector_out, flags_out, rd_out, sticky_flags, count
  );

  modport master (
    output in_valid, vector_in, flags_in, rd_in, out_ready, flush, clear_sticky,
    input  in_ready, out_valid, vector_out, flags_out, rd_out, sticky_flags, count
  );
endinterface

// File: rtl/vector_result_buffer.sv
// Two-entry in-order result buffer between vector execute and writeback, with a sticky
// accumulator of the lane flags of every entry retired since the last clear.
module vector_result_buffer #(
  parameter int LANES = 6,
  parameter int WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  vector_result_buffer_if.slave bus
);

  typedef struct packed {
    logic [LANES*WIDTH-1:0] vec;
    logic [2*LANES-1:0]     flags;
    logic [2:0]             rd;
  } entry_t;

  entry_t               head_q, head_d;
  entry_t               tail_q, tail_d;
  entry_t               in_entry;
  logic [1:0]           count_q, count_d;
  logic [2*LANES-1:0]   sticky_q, sticky_d;
  logic                 push;
  logic                 pop;

  assign in_entry = '{vec: bus.vector_in, flags: bus.flags_in, rd: bus.rd_in};

  // Ready depends only on registered occupancy, so no combinational path from out_ready.
  assign bus.in_ready  = (count_q < 2'd2);
  assign bus.out_valid = (count_q != 2'd0);

  assign push = bus.in_valid  & bus.in_ready;
  assign pop  = bus.out_valid & bus.out_ready;

  // The head register is the output; empty slots are kept at zero so the outputs read zero
  // whenever the buffer is empty.
  assign bus.vector_out   = head_q.vec;
  assign bus.flags_out    = head_q.flags;
  assign bus.rd_out       = head_q.rd;
  assign bus.sticky_flags = sticky_q;
  assign bus.count        = count_q;

  // NOTE: every variable gets a default at the top of always_comb so no path can infer a latch.
  always_comb begin
    head_d   = head_q;
    tail_d   = tail_q;
    count_d  = count_q;
    sticky_d = sticky_q;

    if (bus.flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = 2'd0;
      if (bus.clear_sticky) sticky_d = '0;
    end else begin
      // Clear is applied before the OR so a retiring entry survives a simultaneous clear.
      if (bus.clear_sticky) sticky_d = '0;
      if (pop)              sticky_d = sticky_d | head_q.flags;

      unique case ({push, pop})
        2'b10: begin
          if (count_q == 2'd0) head_d = in_entry;
          else                 tail_d = in_entry;
          count_d = count_q + 2'd1;
        end
        2'b01: begin
          head_d  = tail_q;
          tail_d  = '0;
          count_d = count_q - 2'd1;
        end
        2'b11: begin
          // Only reachable with one entry held: the new result replaces the retiring head.
          head_d = in_entry;
        end
        default: ;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments; the data slots are reset too because
  // the outputs must read zero while reset is held.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_q   <= '0;
      tail_q   <= '0;
      count_q  <= 2'd0;
      sticky_q <= '0;
    end else begin
      head_q   <= head_d;
      tail_q   <= tail_d;
      count_q  <= count_d;
      sticky_q <= sticky_d;
    end
  end

endmodule

// File: tb/tb_vector_result_buffer.sv
// Directed and short random stimulus for vector_result_buffer, checked against a queue
// scoreboard plus a reference occupancy and sticky-flag model.
module tb_vector_result_buffer;

  localparam int LANES = 6;
  localparam int WIDTH = 8;

  typedef struct packed {
    logic [LANES*WIDTH-1:0] vec;
    logic [2*LANES-1:0]     flags;
    logic [2:0]             rd;
  } entry_t;

  logic clk = 1'b0;
  logic reset;
  int   checks   = 0;
  int   failures = 0;

  entry_t             sb[$];
  logic [2*LANES-1:0] sticky_m;

  vector_result_buffer_if #(.LANES(LANES), .WIDTH(WIDTH)) bus ();

  vector_result_buffer #(.LANES(LANES), .WIDTH(WIDTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic iv, input logic [LANES*WIDTH-1:0] v, input logic [2*LANES-1:0] f,
                       input logic [2:0] rd, input logic ordy, input logic fl, input logic cs);
    bus.in_valid     = iv;
    bus.vector_in    = v;
    bus.flags_in     = f;
    bus.rd_in        = rd;
    bus.out_ready    = ordy;
    bus.flush        = fl;
    bus.clear_sticky = cs;
  endtask

  task automatic check_outputs(input string tag);
    entry_t h;
    h = (sb.size() != 0) ? sb[0] : entry_t'('0);
    check({tag, ".count"},     64'(bus.count),        64'(sb.size()));
    check({tag, ".out_valid"}, 64'(bus.out_valid),    64'(sb.size() != 0));
    check({tag, ".in_ready"},  64'(bus.in_ready),     64'(sb.size() < 2));
    check({tag, ".vector"},    64'(bus.vector_out),   64'(h.vec));
    check({tag, ".flags"},     64'(bus.flags_out),    64'(h.flags));
    check({tag, ".rd"},        64'(bus.rd_out),       64'(h.rd));
    check({tag, ".sticky"},    64'(bus.sticky_flags), 64'(sticky_m));
  endtask

  // Called just after a falling edge with inputs already driven: compare, advance model, clock.
  task automatic cycle(input string tag);
    logic   pop_m;
    logic   push_m;
    entry_t e;
    check_outputs(tag);
    pop_m  = (sb.size() != 0) && bus.out_ready;
    push_m = bus.in_valid && (sb.size() < 2);
    e      = '{vec: bus.vector_in, flags: bus.flags_in, rd: bus.rd_in};
    if (bus.flush) begin
      sb.delete();
      if (bus.clear_sticky) sticky_m = '0;
    end else begin
      if (bus.clear_sticky) sticky_m = '0;
      if (pop_m) begin
        sticky_m = sticky_m | sb[0].flags;
        void'(sb.pop_front());
      end
      if (push_m) sb.push_back(e);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    sticky_m = '0;
    reset    = 1'b1;
    drive(1'b0, '0, '0, 3'd0, 1'b0, 1'b0, 1'b0);
    #1;
    check_outputs("reset");
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Single push, then held for five cycles with out_ready low.
    drive(1'b1, 48'h0605_0403_0201, 12'h001, 3'd3, 1'b0, 1'b0, 1'b0);
    cycle("push1");
    drive(1'b0, '0, '0, 3'd0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) cycle("hold");

    // Fill to two; a third in_valid while full is ignored.
    drive(1'b1, 48'hA1A2_A3A4_A5A6, 12'h800, 3'd5, 1'b0, 1'b0, 1'b0);
    cycle("push2");
    drive(1'b1, 48'hDEAD_BEEF_0000, 12'h3FF, 3'd7, 1'b0, 1'b0, 1'b0);
    cycle("full_ignore");
    drive(1'b0, '0, '0, 3'd0, 1'b1, 1'b0, 1'b0);
    cycle("drain1");
    cycle("drain2");
    drive(1'b0, '0, '0, 3'd0, 1'b0, 1'b0, 1'b0);
    cycle("empty_sticky801");
    check("sticky_801", 64'(bus.sticky_flags), 64'h801);

    // Simultaneous push/pop at count 1, together with clear_sticky.
    drive(1'b1, 48'h1111_2222_3333, 12'h004, 3'd1, 1'b0, 1'b0, 1'b0);
    cycle("push_a");
    drive(1'b1, 48'h4444_5555_6666, 12'h010, 3'd2, 1'b1, 1'b0, 1'b1);
    cycle("push_pop_clear");
    drive(1'b0, '0, '0, 3'd0, 1'b0, 1'b0, 1'b0);
    cycle("after_push_pop");
    check("sticky_004", 64'(bus.sticky_flags), 64'h004);
    check("rd_new_head", 64'(bus.rd_out), 64'd2);
    drive(1'b0, '0, '0, 3'd0, 1'b1, 1'b0, 1'b0);
    cycle("pop_b");

    // Flush at count 2 with a coincident push and pop.
    drive(1'b1, 48'h0102_0304_0506, 12'h020, 3'd4, 1'b0, 1'b0, 1'b0);
    cycle("pre_flush1");
    drive(1'b1, 48'h0708_090A_0B0C, 12'h040, 3'd6, 1'b0, 1'b0, 1'b0);
    cycle("pre_flush2");
    drive(1'b1, 48'hFFFF_FFFF_FFFF, 12'hFFF, 3'd7, 1'b1, 1'b1, 1'b0);
    cycle("flush");
    drive(1'b0, '0, '0, 3'd0, 1'b0, 1'b0, 1'b0);
    cycle("post_flush");

    // Reset asserted between edges with two entries held.
    drive(1'b1, 48'h0A0B_0C0D_0E0F, 12'h100, 3'd1, 1'b0, 1'b0, 1'b0);
    cycle("pre_rst1");
    drive(1'b1, 48'h1A1B_1C1D_1E1F, 12'h200, 3'd2, 1'b0, 1'b0, 1'b0);
    cycle("pre_rst2");
    drive(1'b0, '0, '0, 3'd0, 1'b0, 1'b0, 1'b0);
    check("pre_rst_count", 64'(bus.count), 64'd2);
    #2;
    reset = 1'b1;
    sb.delete();
    sticky_m = '0;
    #1;
    check_outputs("async_rst");
    @(negedge clk);
    reset = 1'b0;

    // First push after reset behaves as into an empty buffer.
    drive(1'b1, 48'h0123_4567_89AB, 12'h002, 3'd5, 1'b0, 1'b0, 1'b0);
    cycle("post_rst_push");
    drive(1'b0, '0, '0, 3'd0, 1'b1, 1'b0, 1'b0);
    cycle("post_rst_pop");

    // Short random run against the same model.
    for (int i = 0; i < 60; i++) begin
      drive(1'($urandom_range(0, 1)), {$urandom(), 16'($urandom())}, 12'($urandom()),
            3'($urandom()), 1'($urandom_range(0, 1)), ($urandom_range(0, 11) == 0),
            ($urandom_range(0, 7) == 0));
      cycle("random");
    end
    drive(1'b0, '0, '0, 3'd0, 1'b0, 1'b0, 1'b0);
    cycle("final");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vector_result_buffer.md
VECTOR_RESULT_BUFFER -- requirements
Module: vector_result_buffer

Interface
REQ-001 SHALL have parameter LANES, default 6, number of vector lanes.
REQ-002 SHALL have parameter WIDTH, default 8, bits per lane.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1  execute-stage result valid.
REQ-006 SHALL have port in_ready  output  1  buffer can accept a result this cycle.
REQ-007 SHALL have port vector_in  input  LANES*WIDTH  packed lane results, lane i at bits [WIDTH*i+WIDTH-1 : WIDTH*i].
REQ-008 SHALL have port flags_in  input  2*LANES  packed lane flags, lane i at bits [2i+1:2i].
REQ-009 SHALL have port rd_in  input  3  destination vector register index.
REQ-010 SHALL have port out_valid  output  1  head entry valid.
REQ-011 SHALL have port out_ready  input  1  downstream accepts head entry.
REQ-012 SHALL have ports vector_out (LANES*WIDTH), flags_out (2*LANES), rd_out (3)  outputs  head entry contents.
REQ-013 SHALL have port flush  input  1  discard all buffered entries.
REQ-014 SHALL have port clear_sticky  input  1  clear sticky flag accumulator.
REQ-015 SHALL have port sticky_flags  output  2*LANES  OR of flags of all entries popped since last clear/reset.
REQ-016 SHALL have port count  output  2  number of occupied entries (0..2).

Function
REQ-017 SHALL implement a 2-entry in-order FIFO; push = in_valid & in_ready; pop = out_valid & out_ready.
REQ-018 SHALL drive in_ready = (count < 2), combinationally from registered count only (no dependence on out_ready).
REQ-019 SHALL drive out_valid = (count != 0).
REQ-020 SHALL present a pushed entry on outputs starting the cycle after the push edge (1-cycle latency) when buffer was empty.
REQ-021 SHALL hold vector_out, flags_out, rd_out stable while out_valid=1 and out_ready=0.
REQ-022 SHALL, on push and pop in the same cycle with count=1, keep count=1 and present the new entry as head next cycle.
REQ-023 SHALL, with count=2, ignore in_valid (no push); pop alone drops count to 1 with second entry becoming head.
REQ-024 SHALL, on flush=1 at a clock edge, set count=0 and discard all entries; flush overrides any simultaneous push or pop; a pop coincident with flush SHALL NOT update sticky_flags.
REQ-025 SHALL, on each pop, update sticky_flags <= sticky_flags | flags_out.
REQ-026 SHALL, on clear_sticky with simultaneous pop, load sticky_flags <= flags_out (clear applied before OR).
REQ-027 SHALL drive vector_out, flags_out, rd_out to zero whenever count=0.
REQ-028 SHALL never overflow or underflow count; writes/reads outside the handshake rules SHALL have no effect.

Reset
REQ-029 SHALL, while reset=1, asynchronously force count=0, out_valid=0, in_ready=1, sticky_flags=0, vector_out=0, flags_out=0, rd_out=0.
REQ-030 SHALL, on reset asserted mid-operation, discard all entries; first push after reset deassertion behaves as into an empty buffer.

Verification
REQ-031 SHALL cover single push: vector_in=0x0605_0403_0201, flags_in=0x001, rd_in=3, out_ready=0 -> next cycle out_valid=1, vector_out=0x060504030201, rd_out=3, count=1, held for 5 cycles.
REQ-032 SHALL cover fill: two pushes with out_ready=0 -> count=2, in_ready=0; third in_valid ignored; then out_ready=1 for 2 cycles -> entries emerge in order, count=0.
REQ-033 SHALL cover simultaneous push/pop at count=1 -> count stays 1, new rd_out visible next cycle.
REQ-034 SHALL cover sticky: pop flags 0x001 then 0x800 -> sticky_flags=0x801; clear_sticky with pop of 0x004 -> sticky_flags=0x004.
REQ-035 SHALL cover flush with count=2 plus coincident in_valid and out_ready -> count=0, out_valid=0, sticky_flags unchanged.
REQ-036 SHALL cover reset asserted between clock edges with count=2 -> outputs zero immediately, in_ready=1 without a clock edge.
